// File: rtl/riscv_instr_obi_fetch.sv
// riscv_instr_obi_fetch
// Instruction-side OBI bus master. It issues word-aligned sequential fetches,
// tracks the granted-but-unreturned transactions, buffers returned words in a
// small FIFO and hands {addr, rdata, err} to the IF stage over valid/ready.
// A branch flushes the FIFO and marks every in-flight response as stale.
// Optional feature macro: RISCV_FETCH_BYPASS_EN. When it is defined, a returning
// word falls straight through to the IF stage in its rvalid cycle while the
// FIFO is empty and nothing stale is still in flight.
module riscv_instr_obi_fetch #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_pmp_i
);

  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

  // Next FIFO slot, wrapping at DEPTH (which need not be a power of two).
  function automatic logic [PW-1:0] fifo_ptr_inc(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PW'(DEPTH - 1)) nxt = {PW{1'b0}};
    else                       nxt = ptr + PW'(1);
    return nxt;
  endfunction

  // Next response-address queue slot, wrapping at MAX_OUTSTANDING.
  function automatic logic [QW-1:0] rq_ptr_inc(input logic [QW-1:0] ptr);
    logic [QW-1:0] nxt;
    if (ptr == QW'(MAX_OUTSTANDING - 1)) nxt = {QW{1'b0}};
    else                                 nxt = ptr + QW'(1);
    return nxt;
  endfunction

  // Fetch address generation and the held (ungranted) request.
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic          held_q, held_d;
  logic          redirect_q, redirect_d;
  // Transaction accounting.
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  // Response FIFO.
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_addr_d [DEPTH];
  logic [31:0]   fifo_rdata_q [DEPTH];
  logic [31:0]   fifo_rdata_d [DEPTH];
  logic          fifo_err_q [DEPTH];
  logic          fifo_err_d [DEPTH];
  // Addresses of granted transactions, in grant order.
  logic [31:0]   rq_addr_q [MAX_OUTSTANDING];
  logic [31:0]   rq_addr_d [MAX_OUTSTANDING];
  logic [QW-1:0] rq_wr_q, rq_wr_d;
  logic [QW-1:0] rq_rd_q, rq_rd_d;

  logic          issue_ok_s;
  logic          gnt_s;
  logic          rvalid_ok_s;
  logic          keep_s;
  logic          disc_dec_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   rq_head_s;
  logic [31:0]   branch_target_s;

  // Bus request, transaction bookkeeping and next-state computation.
  always_comb begin
    branch_target_s = branch_addr_i & 32'hFFFF_FFFC;
    issue_ok_s  = (outstanding_q < MAX_C) &&
                  (({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
    // A request once shown is held with its address until granted.
    instr_req_o  = held_q | (req_i & issue_ok_s);
    instr_addr_o = held_q ? hold_addr_q : fetch_addr_q;
    gnt_s        = instr_req_o & instr_gnt_i;
    // Responses with nothing outstanding (e.g. after a reset) are strays.
    rvalid_ok_s  = instr_rvalid_i & (outstanding_q != CNT_ZERO);
    disc_dec_s   = rvalid_ok_s & (discard_q != CNT_ZERO);
    keep_s       = rvalid_ok_s & (discard_q == CNT_ZERO) & ~branch_i;
    rq_head_s    = rq_addr_q[rq_rd_q];

`ifdef RISCV_FETCH_BYPASS_EN
    bypass_s = keep_s & (fifo_cnt_q == CNT_ZERO);
`else
    bypass_s = 1'b0;
`endif

    push_s = keep_s & ~(bypass_s & ready_i);
    pop_s  = (fifo_cnt_q != CNT_ZERO) & ready_i & ~branch_i;

    held_d      = instr_req_o & ~instr_gnt_i;
    hold_addr_d = instr_addr_o;
    // Remember that the held request no longer belongs to the current stream.
    redirect_d  = held_d & (branch_i | redirect_q);

    if (branch_i) begin
      fetch_addr_d = branch_target_s;
    end else if (gnt_s && !redirect_q) begin
      fetch_addr_d = instr_addr_o + 32'd4;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end

    outstanding_d = outstanding_q + CW'(gnt_s) - CW'(rvalid_ok_s);

    if (branch_i) begin
      // Everything still in flight at the end of this cycle is stale.
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q - CW'(disc_dec_s) + CW'(gnt_s & redirect_q);
    end

    if (branch_i) begin
      fifo_cnt_d = CNT_ZERO;
      fifo_wr_d  = {PW{1'b0}};
      fifo_rd_d  = {PW{1'b0}};
    end else begin
      fifo_cnt_d = fifo_cnt_q + CW'(push_s) - CW'(pop_s);
      fifo_wr_d  = push_s ? fifo_ptr_inc(fifo_wr_q) : fifo_wr_q;
      fifo_rd_d  = pop_s ? fifo_ptr_inc(fifo_rd_q) : fifo_rd_q;
    end

    for (int i = 0; i < DEPTH; i++) begin
      fifo_addr_d[i]  = (push_s && (fifo_wr_q == PW'(i))) ? rq_head_s : fifo_addr_q[i];
      fifo_rdata_d[i] = (push_s && (fifo_wr_q == PW'(i))) ? instr_rdata_i : fifo_rdata_q[i];
      fifo_err_d[i]   = (push_s && (fifo_wr_q == PW'(i))) ? instr_err_pmp_i : fifo_err_q[i];
    end

    rq_wr_d = gnt_s ? rq_ptr_inc(rq_wr_q) : rq_wr_q;
    rq_rd_d = rvalid_ok_s ? rq_ptr_inc(rq_rd_q) : rq_rd_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      rq_addr_d[i] = (gnt_s && (rq_wr_q == QW'(i))) ? instr_addr_o : rq_addr_q[i];
    end

    busy_o = (outstanding_q != CNT_ZERO) | instr_req_o;
  end

  // IF-stage output: FIFO head, or the returning word when it falls through.
  always_comb begin
    if (bypass_s) begin
      valid_o = 1'b1;
      rdata_o = instr_rdata_i;
      addr_o  = rq_head_s;
      err_o   = instr_err_pmp_i;
    end else begin
      valid_o = (fifo_cnt_q != CNT_ZERO);
      rdata_o = fifo_rdata_q[fifo_rd_q];
      addr_o  = fifo_addr_q[fifo_rd_q];
      err_o   = fifo_err_q[fifo_rd_q];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_q  <= 32'd0;
      hold_addr_q   <= 32'd0;
      held_q        <= 1'b0;
      redirect_q    <= 1'b0;
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      fifo_cnt_q    <= CNT_ZERO;
      fifo_wr_q     <= {PW{1'b0}};
      fifo_rd_q     <= {PW{1'b0}};
      rq_wr_q       <= {QW{1'b0}};
      rq_rd_q       <= {QW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i]  <= 32'd0;
        fifo_rdata_q[i] <= 32'd0;
        fifo_err_q[i]   <= 1'b0;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        rq_addr_q[i] <= 32'd0;
      end
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      hold_addr_q   <= hold_addr_d;
      held_q        <= held_d;
      redirect_q    <= redirect_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      rq_wr_q       <= rq_wr_d;
      rq_rd_q       <= rq_rd_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i]  <= fifo_addr_d[i];
        fifo_rdata_q[i] <= fifo_rdata_d[i];
        fifo_err_q[i]   <= fifo_err_d[i];
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        rq_addr_q[i] <= rq_addr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_riscv_instr_obi_fetch.sv
// Testbench for riscv_instr_obi_fetch: the bench plays instruction memory and
// IF stage, and keeps a transaction-level model (epoch-tagged grant queue plus
// an expected-word queue) against which every cycle's outputs are judged.
module tb_riscv_instr_obi_fetch;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        busy_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_pmp_i;

  always #5 clk = ~clk;

  riscv_instr_obi_fetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_pmp_i(instr_err_pmp_i)
  );

  typedef struct { logic [31:0] addr; int epoch; } txn_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } word_t;

  txn_t        mem_q[$];   // granted, not yet returned (bus-side view)
  word_t       exp_q[$];   // current-stream words returned, not yet consumed
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_epoch = 0;
  int          held_epoch = 0;
  bit          held_prev = 1'b0;
  logic [31:0] held_addr = 32'd0;
  logic [31:0] stream_addr = 32'd0;
  int          stray_n = 0;
  int          p_gnt = 100, p_rvalid = 100, p_ready = 100, p_req = 100;
  logic [31:0] err_addr = 32'h0000_010C;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus/IF cycle: drive, let the bus answer the request, check, update model.
  task automatic step(input bit do_branch, input logic [31:0] baddr);
    bit    rv;
    bit    exp_req;
    bit    exp_valid;
    bit    bypass_now;
    int    ep;
    txn_t  t;
    word_t hd;
    @(negedge clk);
    req_i         = ($urandom_range(99) < p_req);
    ready_i       = ($urandom_range(99) < p_ready);
    branch_i      = do_branch;
    branch_addr_i = do_branch ? baddr : $urandom;
    rv = 1'b0;
    t  = '{32'd0, -1};
    if (stray_n > 0) begin
      stray_n--;
      instr_rvalid_i  = 1'b1;
      instr_rdata_i   = $urandom;
      instr_err_pmp_i = 1'b1;
    end else begin
      rv = (mem_q.size() != 0) && ($urandom_range(99) < p_rvalid);
      instr_rvalid_i = rv;
      if (rv) begin
        t = mem_q[0];
        instr_rdata_i   = mem_data(t.addr);
        instr_err_pmp_i = (t.addr == err_addr);
      end else begin
        instr_rdata_i   = $urandom;
        instr_err_pmp_i = $urandom_range(1);
      end
    end
    #1;
    instr_gnt_i = instr_req_o && ($urandom_range(99) < p_gnt);
    #1;

    exp_req = held_prev ||
              (req_i && (mem_q.size() < MAXO) && (mem_q.size() + exp_q.size() < DEPTH));
    check_eq("instr_req", instr_req_o, exp_req);
    if (held_prev) check_eq("held_addr", instr_addr_o, held_addr);
    check_eq("addr_align", instr_addr_o[1:0], 32'd0);
    check_eq("busy", busy_o, (mem_q.size() != 0) || exp_req);

    bypass_now = 1'b0;
`ifdef RISCV_FETCH_BYPASS_EN
    bypass_now = rv && (exp_q.size() == 0) && (t.epoch == cur_epoch) && !do_branch;
`endif
    exp_valid = (exp_q.size() != 0) || bypass_now;
    check_eq("valid", valid_o, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() != 0) hd = exp_q[0];
      else                   hd = '{t.addr, mem_data(t.addr), (t.addr == err_addr)};
      check_eq("addr_o", addr_o, hd.addr);
      check_eq("rdata_o", rdata_o, hd.data);
      check_eq("err_o", err_o, hd.err);
    end

    // Grant: the word belongs to the stream that was current when it was first shown.
    if (instr_req_o && instr_gnt_i) begin
      ep = held_prev ? held_epoch : cur_epoch;
      if (ep == cur_epoch) begin
        check_eq("fetch_addr", instr_addr_o, stream_addr);
        stream_addr = stream_addr + 32'd4;
      end
      mem_q.push_back('{instr_addr_o, ep});
    end

    // Consumption by the IF stage.
    if (exp_valid && ready_i && !do_branch && (exp_q.size() != 0)) void'(exp_q.pop_front());

    // Response: only current-stream words reach the IF stage.
    if (rv) begin
      void'(mem_q.pop_front());
      if ((t.epoch == cur_epoch) && !do_branch && !(bypass_now && ready_i))
        exp_q.push_back('{t.addr, mem_data(t.addr), (t.addr == err_addr)});
    end

    if (instr_req_o && !instr_gnt_i) begin
      if (!held_prev) held_epoch = cur_epoch;
      held_prev = 1'b1;
      held_addr = instr_addr_o;
    end else begin
      held_prev = 1'b0;
    end

    if (do_branch) begin
      cur_epoch++;
      exp_q.delete();
      stream_addr = {baddr[31:2], 2'b00};
    end
    @(posedge clk);
  endtask

  // Reset (possibly mid-transaction); returns still in flight become strays.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    stray_n = mem_q.size();
    mem_q.delete(); exp_q.delete();
    held_prev = 1'b0; cur_epoch++; stream_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", valid_o, 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_addr", addr_o, 32'd0);
    check_eq("rst_err", err_o, 32'd0);
    check_eq("rst_busy", busy_o, 32'd0);
    check_eq("rst_req", instr_req_o, 32'd0);
    check_eq("rst_iaddr", instr_addr_o, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int g, input int rv, input int rd, input int rq);
    p_gnt = g; p_rvalid = rv; p_ready = rd; p_req = rq;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'd0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'd0; instr_err_pmp_i = 1'b0;
    do_reset();

    // Sequential stream from 0x100 (includes the PMP-faulting word at 0x10C).
    set_knobs(100, 100, 100, 100);
    step(1'b1, 32'h0000_0100);
    repeat (20) step(1'b0, 32'd0);

    // Backpressure, then resume.
    set_knobs(100, 100, 0, 100);
    repeat (8) step(1'b0, 32'd0);
    set_knobs(100, 100, 100, 100);
    repeat (6) step(1'b0, 32'd0);

    // Branch with two responses outstanding.
    set_knobs(100, 0, 100, 100);
    repeat (3) step(1'b0, 32'd0);
    step(1'b1, 32'h0000_2000);
    set_knobs(100, 100, 100, 100);
    repeat (10) step(1'b0, 32'd0);

    // Branch while a request sits ungranted.
    set_knobs(0, 100, 100, 100);
    repeat (2) step(1'b0, 32'd0);
    step(1'b1, 32'h0000_2000);
    repeat (2) step(1'b0, 32'd0);
    set_knobs(100, 100, 100, 100);
    repeat (10) step(1'b0, 32'd0);

    // Address wrap, with a misaligned target.
    step(1'b1, 32'hFFFF_FFFE);
    repeat (10) step(1'b0, 32'd0);

    // Reset with transactions in flight; their late responses are strays.
    set_knobs(100, 0, 100, 100);
    repeat (3) step(1'b0, 32'd0);
    do_reset();
    set_knobs(100, 100, 100, 0);
    repeat (4) step(1'b0, 32'd0);
    set_knobs(100, 100, 100, 100);
    repeat (6) step(1'b0, 32'd0);

    // Randomized traffic with random branches.
    for (int blk = 0; blk < 60; blk++) begin
      set_knobs($urandom_range(100, 20), $urandom_range(100, 20),
                $urandom_range(100, 0), $urandom_range(100, 30));
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(99) < 5) begin
          case ($urandom_range(2))
            0:       tgt = 32'h0000_0100 + ($urandom_range(15) << 2);
            1:       tgt = 32'hFFFF_FFF0 | $urandom_range(15);
            default: tgt = $urandom;
          endcase
          step(1'b1, tgt);
        end else begin
          step(1'b0, 32'd0);
        end
      end
    end

    // Drain.
    set_knobs(100, 100, 100, 0);
    repeat (20) step(1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
